decode_scoreboard: RTL and testbench

DECODE_SCOREBOARD -- requirements
Module: decode_scoreboard

---
 rtl/decode_scoreboard_pkg.sv | 20 ++
 rtl/decode_scoreboard_sb_counter.sv | 27 ++
 rtl/decode_scoreboard.sv | 122 ++++++++++++
 tb/tb_decode_scoreboard.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_scoreboard_pkg.sv
// Shared definitions for the decode scoreboard: register address macros,
// the default in-flight counter width and the drain FSM encoding.
// Optional feature macro: SCOREBOARD_BYPASS_EN (same-cycle writeback forwarding).
`ifndef DECODE_SCOREBOARD_DEFINES
`define DECODE_SCOREBOARD_DEFINES
`define REG_SIZE 32
`define REG_ADDR [4:0]
`endif

package decode_scoreboard_pkg;
  localparam int SB_CNT_W_DEFAULT = 2;
  localparam int SB_ADDR_W        = 5;

  // Drain FSM encoding; also presented on the top-level debug state output.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sb_state_t;
endpackage

// File: rtl/decode_scoreboard_sb_counter.sv
// sb_counter: in-flight write counter for one architectural register.
// Counts up on issue, down on retire, saturates at both ends, and holds
// when both happen in the same cycle.
module sb_counter
  import decode_scoreboard_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Up/down count with saturation; simultaneous inc and dec cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: tracks outstanding writes per architectural register,
// blocks decode on RAW and counter-overflow hazards, counts stall cycles and
// supports a drain (quiesce) handshake.
// Optional feature macro: SCOREBOARD_BYPASS_EN -- a source whose only pending
// write is retiring in the same cycle is not treated as a hazard.
//
// Handshake: an instruction issues in a cycle where dec_valid && issue_ready
// are both high at the rising clock edge; issue_ready never depends on
// dec_valid, and decode must hold its fields stable until issue.
module decode_scoreboard
  import decode_scoreboard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = SB_CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  input  logic `REG_ADDR  dec_src1,
  input  logic `REG_ADDR  dec_src2,
  input  logic            dec_use1,
  input  logic            dec_use2,
  input  logic `REG_ADDR  dec_dst,
  input  logic            dec_wr,
  output logic            issue_ready,
  input  logic            regwrite,
  input  logic `REG_ADDR  wreg,
  input  logic            drain_req,
  output logic            drain_done,
  output logic [15:0]     stall_cycles,
  output logic [1:0]      dbg_state
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sb_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q [`REG_SIZE];
  logic             inc_vec [`REG_SIZE];
  logic             dec_vec [`REG_SIZE];
  logic             issue_fire;
  logic             all_zero;
  logic             raw_hazard, ovf_hazard;
  logic             fwd1, fwd2;
  logic [CNT_W-1:0] c1, c2, cd;

  // One counter per tracked register; unused address slots read as zero.
  for (genvar r = 0; r < `REG_SIZE; r++) begin : g_cnt
    if (r < NREGS) begin : g_live
      sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (inc_vec[r]),
        .dec  (dec_vec[r]),
        .cnt  (cnt_q[r])
      );
    end else begin : g_tie
      assign cnt_q[r] = '0;
    end
  end

  // Per-register increment/decrement strobes and the all-idle flag.
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < `REG_SIZE; i++) begin
      inc_vec[i] = issue_fire && dec_wr && (dec_dst == SB_ADDR_W'(i));
      dec_vec[i] = regwrite && (wreg == SB_ADDR_W'(i));
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  // Hazard detection and issue permission, combinational from current state.
  always_comb begin
    c1 = cnt_q[dec_src1];
    c2 = cnt_q[dec_src2];
    cd = cnt_q[dec_dst];
`ifdef SCOREBOARD_BYPASS_EN
    fwd1 = regwrite && (wreg == dec_src1) && (c1 == CNT_ONE);
    fwd2 = regwrite && (wreg == dec_src2) && (c2 == CNT_ONE);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
    raw_hazard = (dec_use1 && (c1 != '0) && !fwd1) ||
                 (dec_use2 && (c2 != '0) && !fwd2);
    ovf_hazard = dec_wr && (cd == CNT_MAX);
    // A drain request blocks issue in the same cycle it moves RUN to DRAIN.
    issue_ready = !raw_hazard && !ovf_hazard && (state_q == ST_RUN) && !drain_req;
    issue_fire  = dec_valid && issue_ready;
  end

  // Drain FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Drain FSM next-state and outputs.
  always_comb begin
    state_d    = state_q;
    drain_done = 1'b0;
    case (state_q)
      ST_RUN:   if (drain_req) state_d = ST_DRAIN;
      ST_DRAIN: if (all_zero)  state_d = ST_DONE;
      ST_DONE: begin
        drain_done = 1'b1;
        state_d    = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  // Saturating count of cycles where decode holds an instruction but cannot issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (dec_valid && !issue_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

  assign dbg_state = state_q;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Testbench for decode_scoreboard: directed vector table, drain and async
// reset sequences, then randomized traffic against a reference model.
module tb_decode_scoreboard;
  import decode_scoreboard_pkg::*;

  localparam int MAXC = (1 << SB_CNT_W_DEFAULT) - 1;

  typedef struct {
    logic       valid;
    logic [4:0] src1;
    logic       use1;
    logic [4:0] src2;
    logic       use2;
    logic [4:0] dst;
    logic       wr;
    logic       regwrite;
    logic [4:0] wreg;
    logic       drain;
    int         exp_ready;  // -1: no table expectation
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_use1, dec_use2, dec_wr, regwrite, drain_req;
  logic [4:0]  dec_src1, dec_src2, dec_dst, wreg;
  logic        issue_ready, drain_done;
  logic [15:0] stall_cycles;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;

  // Reference model state
  int mcnt [32];
  int mphase;   // 0 run, 1 drain, 2 done
  int mstall;
  bit m_ready;

  decode_scoreboard dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid),
    .dec_src1(dec_src1), .dec_src2(dec_src2), .dec_use1(dec_use1), .dec_use2(dec_use2),
    .dec_dst(dec_dst), .dec_wr(dec_wr), .issue_ready(issue_ready),
    .regwrite(regwrite), .wreg(wreg), .drain_req(drain_req),
    .drain_done(drain_done), .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic valid, input int src1, input logic use1,
                              input int src2, input logic use2, input int dst,
                              input logic wr, input logic rw, input int wr_reg,
                              input logic drain, input int exp_ready);
    vec_t v;
    v.valid = valid; v.src1 = 5'(src1); v.use1 = use1; v.src2 = 5'(src2);
    v.use2 = use2; v.dst = 5'(dst); v.wr = wr; v.regwrite = rw;
    v.wreg = 5'(wr_reg); v.drain = drain; v.exp_ready = exp_ready;
    return v;
  endfunction

  // Reference model: a source is busy while it has pending writes, unless
  // (with forwarding) its single pending write retires this very cycle.
  function automatic bit src_busy(input int s, input vec_t v);
    if (mcnt[s] == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (mcnt[s] == 1 && v.regwrite && int'(v.wreg) == s) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit model_ready(input vec_t v);
    if (mphase != 0 || v.drain) return 1'b0;
    if (v.use1 && src_busy(int'(v.src1), v)) return 1'b0;
    if (v.use2 && src_busy(int'(v.src2), v)) return 1'b0;
    if (v.wr && mcnt[v.dst] == MAXC) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (mcnt[i]) mcnt[i] = 0;
    mphase = 0;
    mstall = 0;
  endtask

  task automatic model_update(input vec_t v);
    bit fire;
    bit all0;
    fire = v.valid && m_ready;
    all0 = 1'b1;
    foreach (mcnt[i]) if (mcnt[i] != 0) all0 = 1'b0;
    if (!(fire && v.wr && v.regwrite && v.dst == v.wreg)) begin
      if (fire && v.wr && mcnt[v.dst] < MAXC) mcnt[v.dst]++;
      if (v.regwrite && mcnt[v.wreg] > 0) mcnt[v.wreg]--;
    end
    if (v.valid && !m_ready && mstall < 65535) mstall++;
    case (mphase)
      0: if (v.drain) mphase = 1;
      1: if (all0) mphase = 2;
      default: mphase = 0;
    endcase
  endtask

  function automatic int phase_code();
    case (mphase)
      0: return int'(ST_RUN);
      1: return int'(ST_DRAIN);
      default: return int'(ST_DONE);
    endcase
  endfunction

  // Driver
  task automatic drive(input vec_t v);
    dec_valid = v.valid; dec_src1 = v.src1; dec_use1 = v.use1;
    dec_src2 = v.src2; dec_use2 = v.use2; dec_dst = v.dst; dec_wr = v.wr;
    regwrite = v.regwrite; wreg = v.wreg; drain_req = v.drain;
  endtask

  // One cycle: drive just after an edge, check mid-cycle, advance the model.
  task automatic step(input string tag, input vec_t v);
    drive(v);
    #3;
    m_ready = model_ready(v);
    if (v.exp_ready >= 0) chk({tag, "_tbl_ready"}, int'(issue_ready), v.exp_ready);
    chk({tag, "_ready"}, int'(issue_ready), int'(m_ready));
    chk({tag, "_done"}, int'(drain_done), int'(mphase == 2));
    chk({tag, "_stall"}, int'(stall_cycles), mstall);
    chk({tag, "_state"}, int'(dbg_state), phase_code());
    if (drain_done) done_pulses++;
    @(posedge clk);
    model_update(v);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  vec_t tbl[$];
  int   bypass_exp;

  initial begin
`ifdef SCOREBOARD_BYPASS_EN
    bypass_exp = 1;
`else
    bypass_exp = 0;
`endif
    //              valid s1 u1 s2 u2 dst wr rw wreg dr exp
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));          // idle after reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1));          // issue dst 5
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));          // RAW on 5
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, bypass_exp)); // retire 5 same cycle
    tbl.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1));          // 5 clear
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1));          // cnt7 = 3
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0));          // overflow stall
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1));          // retire 7
    tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1));          // fourth issue ok
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1));          // cnt9 = 1
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 9, 0, 1));          // inc+dec on 9
    tbl.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0));          // cnt9 still 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1));          // retire 9
    tbl.push_back(mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1));          // 9 clear via src2
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));          // reg 0 write
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));          // reg 0 RAW
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));          // retire 0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));          // underflow guard
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));          // reg 0 clear

    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
    #2;
    chk("reset_state", int'(dbg_state), int'(ST_RUN));
    chk("reset_done", int'(drain_done), 0);
    chk("reset_stall", int'(stall_cycles), 0);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // Drain with two pending writes
    do_reset();
    done_pulses = 0;
    step("drn_a", mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1));
    step("drn_b", mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 1));
    step("drn_req", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("drn_r3", mk(1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0));
    step("drn_r4", mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0));
    step("drn_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("drn_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("drn_run", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("drn_pulses", done_pulses, 1);
    chk("drn_back_run", int'(dbg_state), int'(ST_RUN));

    // Drain with zero counts on entry, request held through DONE
    done_pulses = 0;
    step("zd_req", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("zd_drain", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("zd_done", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("zd_rerun", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step("zd_redrain", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("zd_redone", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("zd_end", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("zd_pulses", done_pulses, 2);

    // Async reset in the middle of a drain with pending writes
    step("ar_a", mk(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1));
    step("ar_req", mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    step("ar_drain", mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, -1));
    #2;
    reset = 1'b1;
    #1;
    chk("ar_state", int'(dbg_state), int'(ST_RUN));
    chk("ar_done", int'(drain_done), 0);
    chk("ar_stall", int'(stall_cycles), 0);
    chk("ar_ready", int'(issue_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 2) == 0, $urandom_range(0, 7),
             $urandom_range(0, 40) == 0, -1);
      step("rnd", v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
